// File: rtl/data_memory_bus_adapter_if.sv
// Data-bus bundle between the load/store adapter (master) and the memory
// slave: beat address, lane data, byte enables and wait/valid handshakes.
interface data_memory_bus_adapter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] bus_address;
  logic [DATA_WIDTH-1:0] bus_read_data;
  logic [DATA_WIDTH-1:0] bus_write_data;
  logic                  bus_wait_req;
  logic                  bus_valid;
  logic [LANES-1:0]      bus_byte_enable;
  logic                  bus_read_enable;
  logic                  bus_write_enable;

  modport master (
    output bus_address,
    output bus_write_data,
    output bus_byte_enable,
    output bus_read_enable,
    output bus_write_enable,
    input  bus_read_data,
    input  bus_wait_req,
    input  bus_valid
  );

  modport slave (
    input  bus_address,
    input  bus_write_data,
    input  bus_byte_enable,
    input  bus_read_enable,
    input  bus_write_enable,
    output bus_read_data,
    output bus_wait_req,
    output bus_valid
  );
endinterface

// File: rtl/data_memory_bus_adapter.sv
// Load/store unit between the core data port and a DATA_WIDTH-wide bus.
// Define MISALIGNED_SPLIT_EN to split bus-word-crossing accesses into two beats.
module data_memory_bus_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [2:0]            data_format,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  data_available,
  output logic                  request_successful,
  output logic                  access_fault,
  data_memory_bus_adapter_if.master bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CW    = OFF_W + 2;
  localparam int BE_W  = 2 * LANES;
  localparam int WD_W  = 2 * DATA_WIDTH;

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT0 = 2'b01,
    ST_REQ1  = 2'b10,
    ST_WAIT1 = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT0 = 2'b01
  } state_t;
`endif

  state_t                state_r;
  state_t                state_next_s;
  logic [OFF_W-1:0]      off_s;
  logic [OFF_W+2:0]      lane_shift_s;
  logic [CW-1:0]         size_bytes_s;
  logic [BE_W-1:0]       size_mask_s;
  logic [BE_W-1:0]       wide_be_s;
  logic [WD_W-1:0]       wide_wd_s;
  logic [WD_W-1:0]       wide_rd_s;
  logic [DATA_WIDTH-1:0] lo_sel_s;
  logic [ADDR_WIDTH-1:0] aligned_s;
  logic [31:0]           raw_s;
  logic [31:0]           ext_data_s;
  logic                  cross_s;
  logic                  illegal_s;
  logic                  req_s;
  logic                  store_s;
  logic                  fault_s;
  logic                  unsigned_s;

  assign off_s        = address[OFF_W-1:0];
  assign lane_shift_s = {off_s, 3'b000};
  assign aligned_s    = {address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign illegal_s    = (data_format[1:0] == 2'b11);
  assign unsigned_s   = data_format[2];
  assign req_s        = read_enable | write_enable;
  assign store_s      = write_enable;
  assign cross_s      = ((CW'(off_s) + size_bytes_s) > CW'(LANES));
  assign wide_be_s    = size_mask_s << off_s;
  assign wide_wd_s    = WD_W'(write_data) << lane_shift_s;

  // Access size decode: byte count and unshifted byte-enable mask.
  always_comb begin
    size_bytes_s = {CW{1'b0}};
    size_mask_s  = {BE_W{1'b0}};
    case (data_format[1:0])
      2'b00: begin
        size_bytes_s = CW'(3'd1);
        size_mask_s  = BE_W'(4'b0001);
      end
      2'b01: begin
        size_bytes_s = CW'(3'd2);
        size_mask_s  = BE_W'(4'b0011);
      end
      2'b10: begin
        size_bytes_s = CW'(3'd4);
        size_mask_s  = BE_W'(4'b1111);
      end
      default: begin
        size_bytes_s = {CW{1'b0}};
        size_mask_s  = {BE_W{1'b0}};
      end
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  logic [DATA_WIDTH-1:0] lo_r;
  logic                  capture_lo_s;

  assign fault_s  = illegal_s;
  // A non-crossing load takes both halves from the current beat.
  assign lo_sel_s = cross_s ? lo_r : bus.bus_read_data;
`else
  logic unused_hi_s;

  assign fault_s     = illegal_s | cross_s;
  assign lo_sel_s    = bus.bus_read_data;
  assign unused_hi_s = ^{wide_be_s[BE_W-1:LANES], wide_wd_s[WD_W-1:DATA_WIDTH]};
`endif

  assign wide_rd_s = {bus.bus_read_data, lo_sel_s};
  assign raw_s     = wide_rd_s[lane_shift_s +: 32];

  // Load result truncation and sign/zero extension.
  always_comb begin
    ext_data_s = 32'h0000_0000;
    case (data_format[1:0])
      2'b00:   ext_data_s = {{24{~unsigned_s & raw_s[7]}}, raw_s[7:0]};
      2'b01:   ext_data_s = {{16{~unsigned_s & raw_s[15]}}, raw_s[15:0]};
      2'b10:   ext_data_s = raw_s;
      default: ext_data_s = 32'h0000_0000;
    endcase
  end

  assign read_data    = data_available ? ext_data_s : 32'h0000_0000;
  assign access_fault = reset & req_s & fault_s;

  // State register and low-beat capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
`ifdef MISALIGNED_SPLIT_EN
      lo_r    <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      state_r <= state_next_s;
`ifdef MISALIGNED_SPLIT_EN
      if (capture_lo_s) begin
        lo_r <= bus.bus_read_data;
      end
`endif
    end
  end

  // Next-state, bus request and completion decode.
  always_comb begin
    state_next_s         = state_r;
    bus.bus_address      = {ADDR_WIDTH{1'b0}};
    bus.bus_write_data   = {DATA_WIDTH{1'b0}};
    bus.bus_byte_enable  = {LANES{1'b0}};
    bus.bus_read_enable  = 1'b0;
    bus.bus_write_enable = 1'b0;
    request_successful   = 1'b0;
    data_available       = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    capture_lo_s         = 1'b0;
`endif
    if (!reset) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && !fault_s) begin
            bus.bus_address      = aligned_s;
            bus.bus_byte_enable  = wide_be_s[LANES-1:0];
            bus.bus_write_data   = wide_wd_s[DATA_WIDTH-1:0];
            bus.bus_write_enable = store_s;
            bus.bus_read_enable  = ~store_s;
            if (!bus.bus_wait_req) begin
              if (!store_s) begin
                request_successful = 1'b1;
                state_next_s       = ST_WAIT0;
`ifdef MISALIGNED_SPLIT_EN
              end else if (cross_s) begin
                state_next_s = ST_REQ1;
`endif
              end else begin
                request_successful = 1'b1;
                state_next_s       = ST_IDLE;
              end
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_WAIT0: begin
          if (bus.bus_valid) begin
`ifdef MISALIGNED_SPLIT_EN
            if (cross_s) begin
              capture_lo_s = 1'b1;
              state_next_s = ST_REQ1;
            end else begin
              data_available = 1'b1;
              state_next_s   = ST_IDLE;
            end
`else
            data_available = 1'b1;
            state_next_s   = ST_IDLE;
`endif
          end else begin
            state_next_s = ST_WAIT0;
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        ST_REQ1: begin
          bus.bus_address      = aligned_s + ADDR_WIDTH'(LANES);
          bus.bus_byte_enable  = wide_be_s[BE_W-1:LANES];
          bus.bus_write_data   = wide_wd_s[WD_W-1:DATA_WIDTH];
          bus.bus_write_enable = store_s;
          bus.bus_read_enable  = ~store_s;
          if (!bus.bus_wait_req) begin
            request_successful = 1'b1;
            state_next_s       = store_s ? ST_IDLE : ST_WAIT1;
          end else begin
            state_next_s = ST_REQ1;
          end
        end
        ST_WAIT1: begin
          if (bus.bus_valid) begin
            data_available = 1'b1;
            state_next_s   = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT1;
          end
        end
`endif
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_bus_adapter.sv
// Directed bench for data_memory_bus_adapter: a 32-bit and a 64-bit instance
// driven cycle by cycle; the split/no-split scenario follows MISALIGNED_SPLIT_EN.
module tb_data_memory_bus_adapter;

  logic clock;
  logic reset;

  logic        re32, we32;
  logic [2:0]  fmt32;
  logic [31:0] addr32, wd32, rd32;
  logic        dav32, rs32, af32;

  logic        re64, we64;
  logic [2:0]  fmt64;
  logic [31:0] addr64, wd64, rd64;
  logic        dav64, rs64, af64;

  int n_cmp  = 0;
  int n_fail = 0;

  data_memory_bus_adapter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
  data_memory_bus_adapter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  data_memory_bus_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
    .clock              (clock),
    .reset              (reset),
    .read_enable        (re32),
    .write_enable       (we32),
    .data_format        (fmt32),
    .address            (addr32),
    .write_data         (wd32),
    .read_data          (rd32),
    .data_available     (dav32),
    .request_successful (rs32),
    .access_fault       (af32),
    .bus                (bus32)
  );

  data_memory_bus_adapter #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
    .clock              (clock),
    .reset              (reset),
    .read_enable        (re64),
    .write_enable       (we64),
    .data_format        (fmt64),
    .address            (addr64),
    .write_data         (wd64),
    .read_data          (rd64),
    .data_available     (dav64),
    .request_successful (rs64),
    .access_fault       (af64),
    .bus                (bus64)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    re32 = 1'b0; we32 = 1'b0; fmt32 = 3'b000; addr32 = 32'h0; wd32 = 32'h0;
    re64 = 1'b0; we64 = 1'b0; fmt64 = 3'b000; addr64 = 32'h0; wd64 = 32'h0;
    bus32.bus_read_data = 32'h0; bus32.bus_wait_req = 1'b0; bus32.bus_valid = 1'b0;
    bus64.bus_read_data = 64'h0; bus64.bus_wait_req = 1'b0; bus64.bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    #1;
    n_cmp++;
    if ({rd32, dav32, rs32, af32} !== 35'h0) begin
      n_fail++; $display("FAIL reset_core32: got %h want 0", {rd32, dav32, rs32, af32});
    end
    n_cmp++;
    if ({bus32.bus_address, bus32.bus_write_data, bus32.bus_byte_enable,
         bus32.bus_read_enable, bus32.bus_write_enable} !== 70'h0) begin
      n_fail++; $display("FAIL reset_bus32: got addr %h be %b re %b we %b want all 0",
        bus32.bus_address, bus32.bus_byte_enable, bus32.bus_read_enable, bus32.bus_write_enable);
    end
    n_cmp++;
    if ({rd64, dav64, rs64, af64, bus64.bus_byte_enable, bus64.bus_read_enable,
         bus64.bus_write_enable, bus64.bus_write_data} !== 109'h0) begin
      n_fail++; $display("FAIL reset_64: got be %b re %b we %b rd %h want all 0",
        bus64.bus_byte_enable, bus64.bus_read_enable, bus64.bus_write_enable, rd64);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    re32 = 1'b1; fmt32 = 3'b000; addr32 = 32'h0000_0103;
    #1;
    n_cmp++;
    if ({bus32.bus_byte_enable, bus32.bus_read_enable, bus32.bus_write_enable, rs32} !== 7'b1000_1_0_1) begin
      n_fail++; $display("FAIL lb_request: got be %b re %b we %b rs %b want 1000 1 0 1",
        bus32.bus_byte_enable, bus32.bus_read_enable, bus32.bus_write_enable, rs32);
    end
    n_cmp++;
    if (bus32.bus_address !== 32'h0000_0100) begin
      n_fail++; $display("FAIL lb_addr: got %h want 00000100", bus32.bus_address);
    end
    n_cmp++;
    if (dav32 !== 1'b0) begin
      n_fail++; $display("FAIL lb_early_dav: got %b want 0", dav32);
    end
    tick();
    bus32.bus_valid = 1'b1; bus32.bus_read_data = 32'h80FF_0000;
    #1;
    n_cmp++;
    if ({dav32, bus32.bus_read_enable} !== 2'b10) begin
      n_fail++; $display("FAIL lb_dav: got dav %b re %b want 1 0", dav32, bus32.bus_read_enable);
    end
    n_cmp++;
    if (rd32 !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_data: got %h want ffffff80", rd32);
    end
    tick();
    re32 = 1'b0; bus32.bus_valid = 1'b0;
    #1;
    n_cmp++;
    if ({dav32, rs32, bus32.bus_read_enable} !== 3'b000) begin
      n_fail++; $display("FAIL lb_done: got dav %b rs %b re %b want 000", dav32, rs32, bus32.bus_read_enable);
    end
  endtask

  task automatic test_store_wait();
    int pulses = 0;
    int held = 0;
    we32 = 1'b1; fmt32 = 3'b001; addr32 = 32'h0000_0102; wd32 = 32'h0000_BEEF;
    for (int i = 0; i < 4; i++) begin
      bus32.bus_wait_req = (i < 3);
      #1;
      if (bus32.bus_write_enable === 1'b1) held++;
      if (rs32 === 1'b1) pulses++;
      n_cmp++;
      if ({bus32.bus_write_data, bus32.bus_byte_enable} !== {32'hBEEF_0000, 4'b1100}) begin
        n_fail++; $display("FAIL sh_lane cycle %0d: got wd %h be %b want beef0000 1100",
          i, bus32.bus_write_data, bus32.bus_byte_enable);
      end
      tick();
    end
    we32 = 1'b0; bus32.bus_wait_req = 1'b0;
    #1;
    if (rs32 === 1'b1) pulses++;
    n_cmp++;
    if (held !== 4) begin
      n_fail++; $display("FAIL sh_held: got %0d cycles want 4", held);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL sh_pulses: got %0d want 1", pulses);
    end
    tick();
  endtask

  task automatic test_store_wins();
    re32 = 1'b1; we32 = 1'b1; fmt32 = 3'b010; addr32 = 32'h0000_0100; wd32 = 32'h1122_3344;
    #1;
    n_cmp++;
    if ({bus32.bus_write_enable, bus32.bus_read_enable, bus32.bus_byte_enable, rs32} !== 7'b1_0_1111_1) begin
      n_fail++; $display("FAIL sw_wins: got we %b re %b be %b rs %b want 1 0 1111 1",
        bus32.bus_write_enable, bus32.bus_read_enable, bus32.bus_byte_enable, rs32);
    end
    n_cmp++;
    if (bus32.bus_write_data !== 32'h1122_3344) begin
      n_fail++; $display("FAIL sw_data: got %h want 11223344", bus32.bus_write_data);
    end
    tick();
    re32 = 1'b0; we32 = 1'b0;
    #1;
    n_cmp++;
    if ({bus32.bus_read_enable, bus32.bus_write_enable, dav32} !== 3'b000) begin
      n_fail++; $display("FAIL sw_after: got re %b we %b dav %b want 000",
        bus32.bus_read_enable, bus32.bus_write_enable, dav32);
    end
  endtask

  task automatic test_illegal_and_stray();
    re32 = 1'b1; fmt32 = 3'b011; addr32 = 32'h0000_0100;
    bus32.bus_valid = 1'b1; bus32.bus_read_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({af32, bus32.bus_byte_enable, bus32.bus_read_enable, rs32, dav32} !== 8'b1_0000_0_0_0) begin
      n_fail++; $display("FAIL illegal_fmt: got af %b be %b re %b rs %b dav %b want 1 0000 0 0 0",
        af32, bus32.bus_byte_enable, bus32.bus_read_enable, rs32, dav32);
    end
    tick();
    re32 = 1'b0;
    #1;
    n_cmp++;
    if ({af32, dav32} !== 2'b00) begin
      n_fail++; $display("FAIL stray_valid: got af %b dav %b want 0 0", af32, dav32);
    end
    bus32.bus_valid = 1'b0;
    tick();
  endtask

`ifdef MISALIGNED_SPLIT_EN
  task automatic test_split_load();
    re32 = 1'b1; fmt32 = 3'b010; addr32 = 32'h0000_0203;
    #1;
    n_cmp++;
    if ({bus32.bus_address, bus32.bus_byte_enable, bus32.bus_read_enable, rs32} !== {32'h0000_0200, 4'b1000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL split_beat0: got addr %h be %b re %b rs %b want 00000200 1000 1 1",
        bus32.bus_address, bus32.bus_byte_enable, bus32.bus_read_enable, rs32);
    end
    tick();
    bus32.bus_valid = 1'b1; bus32.bus_read_data = 32'hAA00_0000;
    #1;
    n_cmp++;
    if ({dav32, bus32.bus_read_enable} !== 2'b00) begin
      n_fail++; $display("FAIL split_wait0: got dav %b re %b want 0 0", dav32, bus32.bus_read_enable);
    end
    tick();
    bus32.bus_valid = 1'b0; bus32.bus_read_data = 32'h0;
    #1;
    n_cmp++;
    if ({bus32.bus_address, bus32.bus_byte_enable, bus32.bus_read_enable, rs32} !== {32'h0000_0204, 4'b0111, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL split_beat1: got addr %h be %b re %b rs %b want 00000204 0111 1 1",
        bus32.bus_address, bus32.bus_byte_enable, bus32.bus_read_enable, rs32);
    end
    tick();
    bus32.bus_valid = 1'b1; bus32.bus_read_data = 32'h00CC_BBDD;
    #1;
    n_cmp++;
    if ({dav32, rd32} !== {1'b1, 32'hCCBB_DDAA}) begin
      n_fail++; $display("FAIL split_data: got dav %b rd %h want 1 ccbbddaa", dav32, rd32);
    end
    tick();
    re32 = 1'b0; bus32.bus_valid = 1'b0;
    #1;
    n_cmp++;
    if ({dav32, rs32, bus32.bus_read_enable} !== 3'b000) begin
      n_fail++; $display("FAIL split_done: got dav %b rs %b re %b want 000", dav32, rs32, bus32.bus_read_enable);
    end
  endtask
`else
  task automatic test_no_split();
    int pulses = 0;
    we32 = 1'b1; fmt32 = 3'b010; addr32 = 32'h0000_0206; wd32 = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rs32 === 1'b1) pulses++;
      n_cmp++;
      if ({af32, bus32.bus_write_enable, bus32.bus_read_enable, bus32.bus_byte_enable} !== 7'b1_0_0_0000) begin
        n_fail++; $display("FAIL nosplit_fault cycle %0d: got af %b we %b re %b be %b want 1 0 0 0000",
          i, af32, bus32.bus_write_enable, bus32.bus_read_enable, bus32.bus_byte_enable);
      end
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL nosplit_pulse: got %0d want 0", pulses);
    end
    we32 = 1'b0;
    #1;
    n_cmp++;
    if (af32 !== 1'b0) begin
      n_fail++; $display("FAIL nosplit_release: got %b want 0", af32);
    end
    tick();
  endtask
`endif

  task automatic test_wide_bus();
    re64 = 1'b1; fmt64 = 3'b101; addr64 = 32'h0000_010E;
    #1;
    n_cmp++;
    if ({bus64.bus_address, bus64.bus_byte_enable, bus64.bus_read_enable, rs64} !== {32'h0000_0108, 8'hC0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL lhu64_req: got addr %h be %h re %b rs %b want 00000108 c0 1 1",
        bus64.bus_address, bus64.bus_byte_enable, bus64.bus_read_enable, rs64);
    end
    tick();
    bus64.bus_valid = 1'b1; bus64.bus_read_data = 64'h8001_0000_0000_0000;
    #1;
    n_cmp++;
    if ({dav64, rd64} !== {1'b1, 32'h0000_8001}) begin
      n_fail++; $display("FAIL lhu64_data: got dav %b rd %h want 1 00008001", dav64, rd64);
    end
    tick();
    re64 = 1'b0; bus64.bus_valid = 1'b0;
    we64 = 1'b1; fmt64 = 3'b000; addr64 = 32'h0000_0105; wd64 = 32'h0000_00A5;
    #1;
    n_cmp++;
    if ({bus64.bus_write_data, bus64.bus_byte_enable, rs64} !== {64'h0000_A500_0000_0000, 8'h20, 1'b1}) begin
      n_fail++; $display("FAIL sb64: got wd %h be %h rs %b want 0000a50000000000 20 1",
        bus64.bus_write_data, bus64.bus_byte_enable, rs64);
    end
    tick();
    we64 = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    re32 = 1'b1; fmt32 = 3'b010; addr32 = 32'h0000_0100;
    tick();
    reset = 1'b0; re32 = 1'b0;
    #1;
    n_cmp++;
    if ({bus32.bus_read_enable, bus32.bus_write_enable, dav32} !== 3'b000) begin
      n_fail++; $display("FAIL abort_in_reset: got re %b we %b dav %b want 000",
        bus32.bus_read_enable, bus32.bus_write_enable, dav32);
    end
    tick();
    reset = 1'b1; bus32.bus_valid = 1'b1; bus32.bus_read_data = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({dav32, bus32.bus_read_enable, bus32.bus_write_enable, rd32} !== 35'h0) begin
      n_fail++; $display("FAIL abort_late_valid: got dav %b re %b we %b rd %h want 0 0 0 0",
        dav32, bus32.bus_read_enable, bus32.bus_write_enable, rd32);
    end
    tick();
    bus32.bus_valid = 1'b0; re32 = 1'b1; addr32 = 32'h0000_0104;
    #1;
    n_cmp++;
    if ({bus32.bus_read_enable, bus32.bus_address} !== {1'b1, 32'h0000_0104}) begin
      n_fail++; $display("FAIL abort_idle: got re %b addr %h want 1 00000104",
        bus32.bus_read_enable, bus32.bus_address);
    end
    tick();
    bus32.bus_valid = 1'b1; bus32.bus_read_data = 32'h0BAD_F00D;
    #1;
    n_cmp++;
    if ({dav32, rd32} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL abort_reload: got dav %b rd %h want 1 0badf00d", dav32, rd32);
    end
    tick();
    re32 = 1'b0; bus32.bus_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_wait();
    test_store_wins();
    test_illegal_and_stray();
`ifdef MISALIGNED_SPLIT_EN
    test_split_load();
`else
    test_no_split();
`endif
    test_wide_bus();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
